// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: tick-timed Moore sequencer for a main/side intersection with pedestrian walk
module traffic_light_fsm #(
    parameter int T_MAIN_MIN   = 8,
    parameter int T_YELLOW     = 3,
    parameter int T_ALL_RED    = 1,
    parameter int T_SIDE_GREEN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       side_sensor,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] state,
    output logic [7:0] remaining
);
    typedef enum logic [2:0] {MG = 3'd0, MY = 3'd1, AR1 = 3'd2, SG = 3'd3, SY = 3'd4, AR2 = 3'd5} state_t;
    logic [2:0] state_q, state_d, nxt;
    logic [7:0] cnt, cnt_d, dur;
    logic       hold, hold_d, ped_pend, ped_d, done, illegal;
    always_comb begin
        illegal = state_q > AR2;
        dur = (state_q == MY || state_q == SY) ? 8'(T_YELLOW) :
              (state_q == AR1 || state_q == AR2) ? 8'(T_ALL_RED) :
              (state_q == SG) ? 8'(T_SIDE_GREEN) : 8'(T_MAIN_MIN);
        done = cnt == dur - 8'd1;
        nxt = (state_q == AR2) ? MG : 3'(state_q + 3'd1);
    end
    // hold marks an expired main-green minimum waiting for demand, so remaining can read 0
    always_comb begin
        state_d = state_q;
        cnt_d = cnt;
        hold_d = hold;
        if (illegal) begin
            state_d = MG;
            cnt_d = 8'd0;
            hold_d = 1'b0;
        end else if (tick && !done) begin
            cnt_d = cnt + 8'd1;
        end else if (tick && (state_q != MG || side_sensor || ped_pend)) begin
            state_d = nxt;
            cnt_d = 8'd0;
            hold_d = 1'b0;
        end else if (tick) begin
            hold_d = 1'b1;
        end
        ped_d = (state_q == AR1 && state_d == SG) ? 1'b0 :
                (ped_req && state_q != SG) ? 1'b1 : ped_pend;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MG;
            cnt <= 8'd0;
            hold <= 1'b0;
            ped_pend <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt <= cnt_d;
            hold <= hold_d;
            ped_pend <= ped_d;
        end
    end
    assign main_light = (state_q == MG) ? 3'b001 : (state_q == MY) ? 3'b010 : 3'b100;
    assign side_light = (state_q == SG) ? 3'b001 : (state_q == SY) ? 3'b010 : 3'b100;
    assign walk = state_q == SG;
    assign state = state_q;
    assign remaining = (illegal || hold) ? 8'd0 : dur - cnt;
endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm: directed and random checks against a phase/elapsed-ticks reference model
module tb_traffic_light_fsm;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       side_sensor = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] main_light, side_light, state;
    logic       walk;
    logic [7:0] remaining;
    int         errors = 0;
    int         checks = 0;
    int         ph = 0;
    int         el = 0;
    bit         pp = 1'b0;
    int         dur_a[6] = '{8, 3, 1, 5, 3, 1};
    logic [2:0] main_a[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] side_a[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    traffic_light_fsm dut (
        .clk(clk), .rst(rst), .tick(tick), .side_sensor(side_sensor), .ped_req(ped_req),
        .main_light(main_light), .side_light(side_light), .walk(walk), .state(state),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: phase index plus ticks spent in it; main green caps elapsed at its minimum
    task automatic step(input bit t, input bit s, input bit p, input bit r);
        int  old;
        bit  served;
        @(negedge clk);
        tick = t;
        side_sensor = s;
        ped_req = p;
        rst = r;
        @(posedge clk);
        if (r) begin
            ph = 0;
            el = 0;
            pp = 1'b0;
        end else begin
            old = ph;
            served = 1'b0;
            if (t) begin
                if (ph == 0) begin
                    if (el + 1 >= dur_a[0] && (s || pp)) begin
                        ph = 1;
                        el = 0;
                    end else el = (el + 1 > dur_a[0]) ? dur_a[0] : el + 1;
                end else if (el + 1 == dur_a[ph]) begin
                    ph = (ph + 1) % 6;
                    el = 0;
                    served = old == 2;
                end else el++;
            end
            pp = served ? 1'b0 : (p && old != 3) ? 1'b1 : pp;
        end
        #1;
        chk("state", state, ph);
        chk("main_light", main_light, main_a[ph]);
        chk("side_light", side_light, side_a[ph]);
        chk("walk", walk, ph == 3);
        chk("remaining", remaining, dur_a[ph] - el);
        chk("ped_pend", dut.ped_pend, pp);
    endtask

    task automatic steer(input int target, input int want_el);
        for (int i = 0; i < 400 && !(ph == target && el == want_el); i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("steer_state", state, target);
    endtask

    initial begin
        bit s;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) step(i[0], 1'b0, 1'b0, 1'b0);
        chk("idle_hold_remaining", remaining, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 168; i++) step(i % 4 == 3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ped_served_hold", state, 3'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        steer(2, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("edge_ped_cleared", dut.ped_pend, 1'b0);
        for (int i = 0; i < 10 && ph == 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("no_second_walk", state, 3'd0);
        steer(3, 2);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_sg_cnt", dut.cnt, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        force dut.state_q = 3'd7;
        #1;
        chk("forced_state", state, 3'd7);
        chk("forced_main_red", main_light, 3'b100);
        chk("forced_side_red", side_light, 3'b100);
        release dut.state_q;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        steer(4, 1);
        for (int i = 0; i < 100; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        chk("frozen_state", state, 3'd4);
        chk("frozen_remaining", remaining, 8'd2);
        s = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) s = ~s;
            step(1'($urandom_range(0, 1)), s, $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
